// File: rtl/tone_pkg.sv
// Shared types, song IDs and note tables for the table-driven tone sequencer.
// TONE_TEST_TABLE switches the default table choice to the short bench table.
package tone_pkg;

    localparam int unsigned TONE_DIV_W = 20;
    localparam int unsigned TONE_DUR_W = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [TONE_DIV_W-1:0] half;
        logic [TONE_DUR_W-1:0] dur;
        logic                  last;
    } note_t;

    localparam logic [7:0] SONG_SPIN  = 8'd0;
    localparam logic [7:0] SONG_WIN   = 8'd1;
    localparam logic [7:0] SONG_LOSE  = 8'd2;
    localparam logic [7:0] SONG_CLEAR = 8'd3;

`ifdef TONE_TEST_TABLE
    localparam bit TONE_TEST_DEFAULT = 1'b1;
`else
    localparam bit TONE_TEST_DEFAULT = 1'b0;
`endif

    // Missing entries terminate the song with one silent tick.
    localparam note_t NOTE_END = '{half: 20'd0, dur: 10'd1, last: 1'b1};

    function automatic note_t mk_note(input logic [19:0] half, input logic [9:0] dur,
                                      input logic last);
        mk_note = '{half: half, dur: dur, last: last};
    endfunction

    // Half-periods below assume a 50 MHz clock; durations are in ms.
    function automatic note_t tone_lookup(input bit test, input logic [7:0] song,
                                          input logic [7:0] idx);
        logic [15:0] key;
        key = {song, idx};
        tone_lookup = NOTE_END;
        if (test) begin
            case (key)
                16'h0000: tone_lookup = mk_note(20'd3, 10'd2, 1'b0);
                16'h0001: tone_lookup = mk_note(20'd0, 10'd1, 1'b1);
                16'h0100: tone_lookup = mk_note(20'd5, 10'd1, 1'b1);
                default:  tone_lookup = NOTE_END;
            endcase
        end else begin
            case (key)
                {SONG_SPIN, 8'd0}:  tone_lookup = mk_note(20'd56818,  10'd40,  1'b0);
                {SONG_SPIN, 8'd1}:  tone_lookup = mk_note(20'd47801,  10'd40,  1'b1);
                {SONG_WIN, 8'd0}:   tone_lookup = mk_note(20'd47801,  10'd120, 1'b0);
                {SONG_WIN, 8'd1}:   tone_lookup = mk_note(20'd37936,  10'd120, 1'b0);
                {SONG_WIN, 8'd2}:   tone_lookup = mk_note(20'd31888,  10'd120, 1'b0);
                {SONG_WIN, 8'd3}:   tone_lookup = mk_note(20'd23877,  10'd400, 1'b1);
                {SONG_LOSE, 8'd0}:  tone_lookup = mk_note(20'd63776,  10'd250, 1'b0);
                {SONG_LOSE, 8'd1}:  tone_lookup = mk_note(20'd0,      10'd50,  1'b0);
                {SONG_LOSE, 8'd2}:  tone_lookup = mk_note(20'd127551, 10'd600, 1'b1);
                {SONG_CLEAR, 8'd0}: tone_lookup = mk_note(20'd23877,  10'd60,  1'b1);
                default:            tone_lookup = NOTE_END;
            endcase
        end
    endfunction

endpackage

// File: rtl/tone_sequencer_rom.sv
// Combinational (song, idx) -> note entry lookup, resized to the sequencer widths.
module tone_rom
    import tone_pkg::*;
#(
    parameter int unsigned NUM_SONGS  = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned DIV_W      = 20,
    parameter int unsigned DUR_W      = 10,
    parameter bit          TEST_TABLE = 1'b0
) (
    input  logic [SEL_W-1:0] song_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [DIV_W-1:0] half_o,
    output logic [DUR_W-1:0] dur_o,
    output logic             last_o
);

    note_t entry_s;

    // Table lookup with out-of-range songs mapped to the terminating rest.
    always_comb begin
        entry_s = tone_lookup(TEST_TABLE, 8'(song_i), 8'(idx_i));
        if (32'(song_i) >= NUM_SONGS) begin
            entry_s = NOTE_END;
        end else begin
            entry_s = entry_s;
        end
        half_o = DIV_W'(entry_s.half);
        dur_o  = DUR_W'(entry_s.dur);
        last_o = entry_s.last;
    end

endmodule

// File: rtl/tone_sequencer.sv
// Table-driven melody engine: steps through note entries of the selected song,
// producing a glitch-free square wave with tick-exact note durations.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned NUM_SONGS  = 4,
    parameter int unsigned MAX_NOTES  = 8,
    parameter int unsigned DIV_W      = 20,
    parameter int unsigned DUR_W      = 10,
    parameter int unsigned GAP_TICKS  = 0,
    parameter bit          TEST_TABLE = TONE_TEST_DEFAULT,
    localparam int unsigned SEL_W     = $clog2(NUM_SONGS),
    localparam int unsigned IDX_W     = $clog2(MAX_NOTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] song_sel,
    input  logic             play,
    input  logic             stop,
    input  logic             loop_en,
    output logic             piezo_out,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] note_idx
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W    = $clog2(TICK_DIV);
    localparam int unsigned GAP_W    = $clog2(GAP_TICKS + 1);
    localparam int unsigned CNT_W    = ((DUR_W > GAP_W) ? DUR_W : GAP_W) + 1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] song_q, song_d;
    logic             loop_q, loop_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             last_q, last_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] tone_q, tone_d;
    logic             phase_q, phase_d;
    logic             piezo_q, piezo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] rom_half_s;
    logic [DUR_W-1:0] rom_dur_s;
    logic             rom_last_s;
    logic             tick_s;
    logic             note_end_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] dur_target_s;

    tone_rom #(
        .NUM_SONGS (NUM_SONGS),
        .SEL_W     (SEL_W),
        .IDX_W     (IDX_W),
        .DIV_W     (DIV_W),
        .DUR_W     (DUR_W),
        .TEST_TABLE(TEST_TABLE)
    ) u_rom (
        .song_i(song_q),
        .idx_i (idx_q),
        .half_o(rom_half_s),
        .dur_o (rom_dur_s),
        .last_o(rom_last_s)
    );

    assign tick_s       = (pre_q == PRE_W'(TICK_DIV - 1));
    assign cnt_inc_s    = cnt_q + CNT_W'(1);
    assign dur_target_s = (dur_q == '0) ? CNT_W'(1) : CNT_W'(dur_q);

    // Next-state, counters and output pre-computation.
    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        loop_d     = loop_q;
        idx_d      = idx_q;
        half_d     = half_q;
        dur_d      = dur_q;
        last_d     = last_q;
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        tone_d     = tone_q;
        phase_d    = phase_q;
        done_d     = 1'b0;
        note_end_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_LOAD: begin
                half_d  = rom_half_s;
                dur_d   = rom_dur_s;
                last_d  = rom_last_s;
                pre_d   = '0;
                cnt_d   = '0;
                tone_d  = '0;
                phase_d = 1'b0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                pre_d = tick_s ? '0 : pre_q + PRE_W'(1);
                if (half_q == '0) begin
                    tone_d = '0;
                end else if (tone_q == half_q - DIV_W'(1)) begin
                    tone_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    tone_d = tone_q + DIV_W'(1);
                end
                if (tick_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s >= dur_target_s) begin
                        if (GAP_TICKS > 0) begin
                            state_d = S_GAP;
                            pre_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            note_end_s = 1'b1;
                        end
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_GAP: begin
                pre_d = tick_s ? '0 : pre_q + PRE_W'(1);
                if (tick_s) begin
                    cnt_d = cnt_inc_s;
                    note_end_s = (cnt_inc_s >= CNT_W'(GAP_TICKS));
                end else begin
                    note_end_s = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (note_end_s) begin
            if (!last_q && (idx_q != IDX_W'(MAX_NOTES - 1))) begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_LOAD;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = S_LOAD;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end else begin
            done_d = 1'b0;
        end

        // Stop dominates; a play in the same cycle is dropped.
        if (stop) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else if (play) begin
            song_d  = song_sel;
            loop_d  = loop_en;
            idx_d   = '0;
            state_d = S_LOAD;
            done_d  = 1'b0;
        end else begin
            song_d = song_q;
        end

        busy_d  = (state_d != S_IDLE);
        piezo_d = (state_d == S_PLAY) && (half_q != '0) && phase_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            song_q  <= '0;
            loop_q  <= 1'b0;
            idx_q   <= '0;
            half_q  <= '0;
            dur_q   <= '0;
            last_q  <= 1'b0;
            pre_q   <= '0;
            cnt_q   <= '0;
            tone_q  <= '0;
            phase_q <= 1'b0;
            piezo_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            loop_q  <= loop_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            dur_q   <= dur_d;
            last_q  <= last_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            phase_q <= phase_d;
            piezo_q <= piezo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign piezo_out = piezo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign note_idx  = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer using the short test table (TICK_DIV = 10).
module tb_tone_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] song_sel;
    logic       play;
    logic       stop;
    logic       loop_en;
    logic       piezo_out;
    logic       busy;
    logic       done;
    logic [2:0] note_idx;

    logic [5:0] exp_q[$];
    int         n_cmp;
    int         n_err;
    int         cyc_n;

    tone_sequencer #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .NUM_SONGS (4),
        .MAX_NOTES (8),
        .DIV_W     (20),
        .DUR_W     (10),
        .GAP_TICKS (0),
        .TEST_TABLE(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .song_sel (song_sel),
        .play     (play),
        .stop     (stop),
        .loop_en  (loop_en),
        .piezo_out(piezo_out),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (piezo,busy,done,idx)", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic p, input logic b, input logic d, input logic [2:0] idx);
        exp_q.push_back({p, b, d, idx});
    endtask

    // LOAD cycle followed by nplay PLAY cycles; the tone rises after half cycles.
    task automatic push_note_part(input int half, input logic [2:0] idx, input int nplay);
        push_exp(1'b0, 1'b1, 1'b0, idx);
        for (int k = 0; k < nplay; k++) begin
            push_exp((half != 0) ? 1'(((k / ((half != 0) ? half : 1)) % 2)) : 1'b0,
                     1'b1, 1'b0, idx);
        end
    endtask

    task automatic push_note(input int half, input int ticks, input logic [2:0] idx);
        push_note_part(half, idx, ticks * 10);
    endtask

    task automatic push_idle(input int n, input logic [2:0] idx);
        for (int k = 0; k < n; k++) push_exp(1'b0, 1'b0, 1'b0, idx);
    endtask

    task automatic step(input int n);
        logic [5:0] e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (exp_q.size() == 0) begin
                check_eq($sformatf("sb_underrun@%0d", cyc_n), 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("out@%0d", cyc_n),
                         {26'd0, piezo_out, busy, done, note_idx}, {26'd0, e});
            end
        end
    endtask

    task automatic drive(input logic p, input logic s, input logic [1:0] sel, input logic lp);
        play     = p;
        stop     = s;
        song_sel = sel;
        loop_en  = lp;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc_n = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        push_idle(2, 3'd0);
        step(2);
        rst_n = 1'b1;
        push_idle(2, 3'd0);
        step(2);

        // Song0 from idle: two notes then done as busy falls.
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        push_note(3, 2, 3'd0);
        push_note(0, 1, 3'd1);
        push_exp(1'b0, 1'b0, 1'b1, 3'd1);
        push_idle(3, 3'd1);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        step(35);

        // Song1 looping, stopped mid third note.
        drive(1'b1, 1'b0, 2'd1, 1'b1);
        push_note(5, 1, 3'd0);
        push_note(5, 1, 3'd0);
        push_note_part(5, 3'd0, 7);
        step(1);
        drive(1'b0, 1'b0, 2'd1, 1'b0);
        step(29);
        drive(1'b0, 1'b1, 2'd1, 1'b0);
        push_idle(3, 3'd0);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        step(2);

        // Song1 preempts song0 mid-note; song0 never reports done.
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        push_note_part(3, 3'd0, 8);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        step(8);
        drive(1'b1, 1'b0, 2'd1, 1'b0);
        push_note(5, 1, 3'd0);
        push_exp(1'b0, 1'b0, 1'b1, 3'd0);
        push_idle(3, 3'd0);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        step(14);

        // Stop together with play, idle then busy.
        drive(1'b1, 1'b1, 2'd1, 1'b0);
        push_idle(1, 3'd0);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        push_idle(2, 3'd0);
        step(2);
        drive(1'b1, 1'b0, 2'd1, 1'b1);
        push_note_part(5, 3'd0, 4);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        step(4);
        drive(1'b1, 1'b1, 2'd0, 1'b0);
        push_idle(1, 3'd0);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        push_idle(3, 3'd0);
        step(3);

        // Song without a table entry: one silent note then done.
        drive(1'b1, 1'b0, 2'd3, 1'b0);
        push_note(0, 1, 3'd0);
        push_exp(1'b0, 1'b0, 1'b1, 3'd0);
        push_idle(2, 3'd0);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        step(13);

        // Reset mid-note, then a clean replay of song0.
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        push_note_part(3, 3'd0, 12);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        step(12);
        rst_n = 1'b0;
        push_idle(1, 3'd0);
        step(1);
        rst_n = 1'b1;
        push_idle(1, 3'd0);
        step(1);
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        push_note(3, 2, 3'd0);
        push_note(0, 1, 3'd1);
        push_exp(1'b0, 1'b0, 1'b1, 3'd1);
        push_idle(2, 3'd1);
        step(1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        step(34);

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
